// File: rtl/serial_parity_checker.sv
// ============================================================================
// Module      : serial_parity_checker
// Description : Receive side of the XOR-parity serial link. Deserialises one
//               LSB-first word plus a trailing parity bit per frame and flags
//               parity mismatches with a saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_vld,
  input  logic                 bit_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int                c_cnt_w    = $clog2(DATA_W + 1);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_accept_bit;
  logic                 w_frame_end;
  logic                 w_frame_bad;

  logic [DATA_W-1:0]    r_shift;
  logic [c_cnt_w-1:0]   r_bit_cnt;
  logic                 r_par;
  logic [DATA_W-1:0]    r_data_out;
  logic                 r_frame_done;
  logic                 r_parity_err;
  logic                 r_busy;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != IDLE);
    end
  end

  // start outranks bit_vld in every state, so a restart drops the coincident bit.
  always_comb begin
    w_next_state = r_state;
    w_accept_bit = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = DATA;
      end
      DATA: begin
        if (start) begin
          w_next_state = DATA;
        end else if (bit_vld) begin
          w_accept_bit = 1'b1;
          if (r_bit_cnt == c_last_bit) w_next_state = PARITY;
        end
      end
      PARITY: begin
        if (start) begin
          w_next_state = DATA;
        end else if (bit_vld) begin
          w_frame_end  = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_frame_bad = r_par ^ bit_in ^ ODD_PARITY;

  // Shifting in from the MSB end places the first received bit at bit 0
  // once all DATA_W bits have arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_data_out   <= '0;
      r_frame_done <= 1'b0;
      r_parity_err <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_frame_done <= w_frame_end;
      if (start) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_par     <= 1'b0;
      end else if (w_accept_bit) begin
        r_shift   <= {bit_in, r_shift[DATA_W-1:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_par     <= r_par ^ bit_in;
      end
      if (w_frame_end) begin
        r_data_out   <= r_shift;
        r_parity_err <= w_frame_bad;
        if (w_frame_bad && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign data_out   = r_data_out;
  assign frame_done = r_frame_done;
  assign parity_err = r_parity_err;
  assign busy       = r_busy;
  assign err_cnt    = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_checker.sv
// ============================================================================
// Module      : tb_serial_parity_checker
// Description : Scoreboard bench driving even, saturating and odd-parity
//               instances of serial_parity_checker from one shared link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_parity_checker;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic start   = 1'b0;
  logic bit_vld = 1'b0;
  logic bit_in  = 1'b0;

  logic [7:0] d0, d1, d2;
  logic       fd0, fd1, fd2;
  logic       pe0, pe1, pe2;
  logic       busy0, busy1, busy2;
  logic [7:0] ec0, ec2;
  logic [1:0] ec1;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1'b0), .ERR_CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_vld(bit_vld), .bit_in(bit_in),
    .data_out(d0), .frame_done(fd0), .parity_err(pe0), .busy(busy0), .err_cnt(ec0));

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1'b0), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_vld(bit_vld), .bit_in(bit_in),
    .data_out(d1), .frame_done(fd1), .parity_err(pe1), .busy(busy1), .err_cnt(ec1));

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1'b1), .ERR_CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_vld(bit_vld), .bit_in(bit_in),
    .data_out(d2), .frame_done(fd2), .parity_err(pe2), .busy(busy2), .err_cnt(ec2));

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] err;   // {even, sat, odd}
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [7:0] cnt2;
  } exp_t;

  exp_t sb[$];
  int   cnt_m0 = 0, cnt_m1 = 0, cnt_m2 = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void push_expected(input logic [7:0] d, input logic p);
    exp_t e;
    logic even_bad;
    even_bad = (^d) ^ p;
    if (even_bad && cnt_m0 < 255) cnt_m0++;
    if (even_bad && cnt_m1 < 3)   cnt_m1++;
    if (!even_bad && cnt_m2 < 255) cnt_m2++;
    e.data = d;
    e.err  = {even_bad, even_bad, ~even_bad};
    e.cnt0 = 8'(cnt_m0);
    e.cnt1 = 2'(cnt_m1);
    e.cnt2 = 8'(cnt_m2);
    sb.push_back(e);
  endfunction

  function automatic void model_reset();
    cnt_m0 = 0;
    cnt_m1 = 0;
    cnt_m2 = 0;
    sb.delete();
  endfunction

  // Scoreboard monitor: every frame_done pops one expected record.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (fd0 || fd1 || fd2)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_frame_done: got fd=%b%b%b required no pulse", fd0, fd1, fd2);
      end else begin
        e = sb.pop_front();
        if ({fd0, fd1, fd2} !== 3'b111) begin
          miscompares++;
          $display("FAIL frame_done_all: got %b required 111", {fd0, fd1, fd2});
        end
        vectors++;
        if (d0 !== e.data || d1 !== e.data || d2 !== e.data) begin
          miscompares++;
          $display("FAIL data_out: got %h/%h/%h required %h", d0, d1, d2, e.data);
        end
        vectors++;
        if ({pe0, pe1, pe2} !== e.err) begin
          miscompares++;
          $display("FAIL parity_err: got %b required %b", {pe0, pe1, pe2}, e.err);
        end
        vectors++;
        if (ec0 !== e.cnt0 || ec1 !== e.cnt1 || ec2 !== e.cnt2) begin
          miscompares++;
          $display("FAIL err_cnt: got %0d/%0d/%0d required %0d/%0d/%0d",
                   ec0, ec1, ec2, e.cnt0, e.cnt1, e.cnt2);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves bit_vld untouched on the start cycle so callers can test start priority.
  task automatic send_frame(input logic [7:0] d, input logic p, input int max_stall);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %b required 1", busy0);
    end
    for (int i = 0; i < 8; i++) begin
      n = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      for (int s = 0; s < n; s++) begin
        bit_vld = 1'b0;
        bit_in  = 1'($urandom);
        tick();
        vectors++;
        if (busy0 !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_stall: got %b required 1", busy0);
        end
      end
      bit_vld = 1'b1;
      bit_in  = d[i];
      tick();
      vectors++;
      if (busy0 !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_data: got %b required 1", busy0);
      end
    end
    bit_vld = 1'b1;
    bit_in  = p;
    push_expected(d, p);
    tick();
    bit_vld = 1'b0;
    bit_in  = 1'b0;
    vectors++;
    if (busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_parity: got %b required 0", busy0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({d0, fd0, pe0, busy0, ec0} !== 19'd0 || {d1, fd1, pe1, busy1, ec1} !== 13'd0 ||
        {d2, fd2, pe2, busy2, ec2} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h %b %b %b %h required all zero", d0, fd0, pe0, busy0, ec0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (busy0 !== 1'b0 || fd0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b fd=%b required 0 0", busy0, fd0);
    end
    model_reset();
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b0, 0);
    repeat (2) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL good_frame_done_missing: got %0d pending required 0", sb.size());
    end
    vectors++;
    if (d0 !== 8'hA5 || pe0 !== 1'b0 || ec0 !== 8'd0 || pe2 !== 1'b1) begin
      miscompares++;
      $display("FAIL good_frame_hold: got %h %b %0d odd=%b required a5 0 0 odd=1", d0, pe0, ec0, pe2);
    end
  endtask

  task automatic test_bad_frame();
    send_frame(8'h01, 1'b0, 0);
    repeat (2) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL bad_frame_done_missing: got %0d pending required 0", sb.size());
    end
    vectors++;
    if (d0 !== 8'h01 || pe0 !== 1'b1 || ec0 !== 8'd1) begin
      miscompares++;
      $display("FAIL bad_frame_hold: got %h %b %0d required 01 1 1", d0, pe0, ec0);
    end
  endtask

  task automatic test_stalls();
    send_frame(8'h3C, 1'b0, 3);
    repeat (2) tick();
    vectors++;
    if (sb.size() != 0 || d0 !== 8'h3C || pe0 !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_frame: got pending=%0d %h %b required 0 3c 0", sb.size(), d0, pe0);
    end
  endtask

  task automatic test_abort();
    bit_vld = 1'b1;
    bit_in  = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_vld = 1'b1;
      bit_in  = 1'b0;
      tick();
    end
    vectors++;
    if (fd0 !== 1'b0 || d0 !== 8'h3C || busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_partial: got fd=%b %h busy=%b required 0 3c 1", fd0, d0, busy0);
    end
    // Restart with a coincident bit_vld=1 that must be dropped.
    bit_vld = 1'b1;
    bit_in  = 1'b0;
    send_frame(8'hFF, 1'b0, 0);
    repeat (2) tick();
    vectors++;
    if (sb.size() != 0 || d0 !== 8'hFF || pe0 !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_frame: got pending=%0d %h %b required 0 ff 0", sb.size(), d0, pe0);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] sat_seq [5];
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h01, 1'b0, 0);
      tick();
      vectors++;
      if (ec1 !== sat_seq[i] || ec0 !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL saturation_%0d: got %0d/%0d required %0d/%0d", i, ec1, ec0, sat_seq[i], i + 1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_vld = 1'b1;
      bit_in  = 1'b1;
      tick();
    end
    bit_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({d0, fd0, pe0, busy0, ec0} !== 19'd0 || ec1 !== 2'd0 || ec2 !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid_frame: got %h %b %b %b %0d required all zero", d0, fd0, pe0, busy0, ec0);
    end
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    send_frame(8'h5A, 1'b0, 0);
    repeat (2) tick();
    vectors++;
    if (sb.size() != 0 || d0 !== 8'h5A || pe0 !== 1'b0 || ec0 !== 8'd0) begin
      miscompares++;
      $display("FAIL after_reset_frame: got pending=%0d %h %b %0d required 0 5a 0 0", sb.size(), d0, pe0, ec0);
    end
  endtask

  task automatic test_odd_parity();
    send_frame(8'hA5, 1'b1, 0);
    repeat (2) tick();
    vectors++;
    if (pe2 !== 1'b0 || pe0 !== 1'b1) begin
      miscompares++;
      $display("FAIL odd_good: got odd=%b even=%b required 0 1", pe2, pe0);
    end
    send_frame(8'h01, 1'b1, 0);
    repeat (2) tick();
    vectors++;
    if (sb.size() != 0 || pe2 !== 1'b1 || ec2 !== 8'd2) begin
      miscompares++;
      $display("FAIL odd_bad: got pending=%0d %b %0d required 0 1 2", sb.size(), pe2, ec2);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      send_frame(8'($urandom), 1'($urandom), (i % 2) * 2);
    end
    repeat (2) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL back_to_back_pending: got %0d required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_stalls();
    test_abort();
    test_saturation();
    test_reset_mid_frame();
    test_odd_parity();
    test_back_to_back();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
